sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Synchronous 8-bit FIFO controller and the initiator for the 16x8 1r1w SRAM macro.
- Converts a valid/ready write stream into SRAM port-0 writes. Issues SRAM port-1 reads and presents the data on a valid/ready read stream.
- Absorbs the macro's one-cycle read latency with a 2-entry output register stage, giving full throughput (1 word/cycle in and out).
- Total capacity: 16 in SRAM plus 2 in output stage, 18 words.

Parameters:
- DATA_WIDTH, 8, word width; must match the macro.
- ADDR_WIDTH, 4, macro address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of SRAM words.

Ports:
- clk  in  1  single clock. Also drives macro clk0 and clk1 externally.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_WIDTH  upstream word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- level  out  ADDR_WIDTH+1  total stored words, 0..RAM_DEPTH+2; saturates at field max if it does not fit.
- sram_csb0  out  1  macro write select, active low.
- sram_addr0  out  ADDR_WIDTH  macro write address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_csb1  out  1  macro read select, active low.
- sram_addr1  out  ADDR_WIDTH  macro read address.
- sram_dout1  in  DATA_WIDTH  macro read data; valid at the first rising edge after the edge that sampled sram_csb1=0.

Behaviour:
- Reset state (asynchronous, applied immediately):
  - wr_ptr=0, rd_ptr=0, sram_cnt=0, inflight=0, obuf empty.
  - out_valid=0, out_data=0, level=0.
  - sram_csb0=1, sram_csb1=1, sram_addr0=0, sram_addr1=0, sram_din0=0.
  - in_ready=0 while rst is high.
- Reset mid-operation: all stored and in-flight data is discarded. Any sram_dout1 returning after reset is ignored.
- Write path:
  - in_ready = !rst && (sram_cnt != RAM_DEPTH).
  - On in_valid && in_ready (combinational): sram_csb0=0, sram_addr0=wr_ptr, sram_din0=in_data.
  - At the clock edge, wr_ptr wraps modulo RAM_DEPTH.
  - Otherwise sram_csb0=1; addr0 and din0 are don't-care but held at their last value.
- Read issue:
  - issue = (sram_cnt != 0) && (obuf_cnt + inflight - pop < 2), where pop = out_valid && out_ready.
  - On issue (combinational): sram_csb1=0, sram_addr1=rd_ptr.
  - At the edge: rd_ptr++ (wraps), inflight<=1.
  - Otherwise sram_csb1=1.
- Read return: at the edge after issue, sram_dout1 is pushed into obuf; inflight<=0 unless a new issue occurs in the same cycle.
- sram_cnt next = sram_cnt + write - issue. A simultaneous write and issue leaves sram_cnt unchanged.
- Address hazard: none by construction. A read issues only when sram_cnt>0, and writes are blocked at sram_cnt=RAM_DEPTH, so addr0 != addr1 in any cycle where both selects are low. The macro returns data written at a previous edge.
- Output stage (obuf):
  - 2-entry register FIFO; out_valid = (obuf_cnt != 0); out_data = obuf head.
  - out_valid and out_data are register outputs.
  - Simultaneous return and pop with obuf_cnt=1: the head is replaced by the returned word and out_valid stays 1.
  - The head must not change while out_valid && !out_ready.
- level = sram_cnt + inflight + obuf_cnt, registered. Writes count at their accept edge; pops count at their pop edge.
- Latency: a word accepted into an empty FIFO at edge N is read-issued in cycle N+1 and appears with out_valid=1 after edge N+2. Write-to-out latency is 2 cycles.
- Throughput:
  - With out_ready held at 1 and in_valid held at 1, one word per cycle in steady state, no bubbles.
  - With out_ready held at 0, the FIFO fills to 18 words: obuf 2, SRAM 16. in_ready then drops.
- Ordering: strict FIFO order across SRAM wrap-around.

Test Plan:
- Reset and idle:
  - Assert rst mid-cycle → immediately sram_csb0=1, sram_csb1=1, out_valid=0, level=0, in_ready=0.
  - Release rst → in_ready=1 on the next cycle.
- Single word:
  - Write 0xA5 at edge N into the empty FIFO → sram_csb0=0 with addr0=0 in cycle N.
  - sram_csb1=0 with addr1=0 in cycle N+1.
  - out_valid=1 and out_data=0xA5 after edge N+2; level=1 throughout until popped.
- Fill with backpressure:
  - Hold out_ready=0 and write 0x00..0x13 → exactly 18 words are accepted (0x00..0x11), then in_ready=0 and level=18.
  - out_data stays 0x00 throughout.
- Drain:
  - From the full state, set out_ready=1 → words 0x00..0x11 appear in order, one per cycle with no gaps.
  - level decrements to 0, out_valid drops after 0x11.
- Streaming wrap-around:
  - Continuous in_valid=1 and out_ready=1 for 40 words (values i*3 mod 256) → all 40 are received in order at 1 word/cycle.
  - rd_ptr and wr_ptr each wrap at least twice.
  - sram_addr0 and sram_addr1 are never equal while both selects are low.
- Reset mid-stream:
  - Assert rst while level=7 and a read is in flight → level=0 and out_valid=0.
  - The stale sram_dout1 return is not presented.
  - A subsequent write of 0x3C emerges as the first output.

Source files
------------

// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready stream bundle between the FIFO controller and its producer/consumer.
// The slave modport is the controller view; the master modport is the environment view.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a 1r1w SRAM macro, with a 2-entry output register stage
// that hides the macro's one-cycle read latency and keeps 1 word/cycle throughput.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_fifo_ctrl_if.slave       s,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam int CNT_W     = $clog2(RAM_DEPTH + 1);
    localparam int LVL_W     = ADDR_WIDTH + 1;
    localparam int LEVEL_MAX = (1 << LVL_W) - 1;

    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX_C = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      sram_cnt_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] addr0_hold_r;
    logic [DATA_WIDTH-1:0] din0_hold_r;
    logic [ADDR_WIDTH-1:0] addr1_hold_r;
    logic [LVL_W-1:0]      level_r;

    logic [1:0]            obuf_cnt_r;
    logic [DATA_WIDTH-1:0] obuf_head_r;
    logic [DATA_WIDTH-1:0] obuf_tail_r;
    logic                  out_valid_r;

    logic                  in_ready_s;
    logic                  wr_en_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occ_s;
    logic [CNT_W-1:0]      sram_cnt_nxt_s;
    logic [1:0]            obuf_cnt_nxt_s;
    logic [31:0]           level_sum_s;
    logic [LVL_W-1:0]      level_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;

    // Handshakes, read-issue decision and next-state counts.
    always_comb begin
        in_ready_s     = 1'b0;
        wr_en_s        = 1'b0;
        pop_s          = 1'b0;
        push_s         = 1'b0;
        issue_s        = 1'b0;
        occ_s          = 3'd0;
        sram_cnt_nxt_s = sram_cnt_r;
        obuf_cnt_nxt_s = obuf_cnt_r;
        level_sum_s    = 32'd0;
        level_nxt_s    = {LVL_W{1'b0}};

        in_ready_s = !rst && (sram_cnt_r != DEPTH_C);
        wr_en_s    = s.in_valid && in_ready_s;
        pop_s      = out_valid_r && s.out_ready;
        push_s     = inflight_r;

        // Output-stage occupancy after this cycle's pop, counting the word in flight.
        occ_s   = {1'b0, obuf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s = !rst && (sram_cnt_r != {CNT_W{1'b0}}) && (occ_s < 3'd2);

        sram_cnt_nxt_s = sram_cnt_r + CNT_W'(wr_en_s) - CNT_W'(issue_s);
        obuf_cnt_nxt_s = obuf_cnt_r + {1'b0, push_s} - {1'b0, pop_s};

        level_sum_s = 32'(sram_cnt_nxt_s) + 32'(issue_s) + 32'(obuf_cnt_nxt_s);
        if (level_sum_s > 32'(LEVEL_MAX)) begin
            level_nxt_s = LVL_W'(LEVEL_MAX);
        end else begin
            level_nxt_s = level_sum_s[LVL_W-1:0];
        end
    end

    // Pointer wrap, written generically so a non-power-of-two depth also works.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_ptr_r == PTR_MAX_C) begin
            wr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_WIDTH'(1);
        end
        if (rd_ptr_r == PTR_MAX_C) begin
            rd_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + ADDR_WIDTH'(1);
        end
    end

    // Macro port drive: selects follow the handshakes, idle address/data hold last use.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_addr0 = addr0_hold_r;
        sram_din0  = din0_hold_r;
        sram_csb1  = 1'b1;
        sram_addr1 = addr1_hold_r;
        if (wr_en_s) begin
            sram_csb0  = 1'b0;
            sram_addr0 = wr_ptr_r;
            sram_din0  = s.in_data;
        end else begin
            sram_csb0  = 1'b1;
        end
        if (issue_s) begin
            sram_csb1  = 1'b0;
            sram_addr1 = rd_ptr_r;
        end else begin
            sram_csb1  = 1'b1;
        end
    end

    // SRAM-side state: pointers, stored count, in-flight flag, held addresses, level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
            sram_cnt_r   <= {CNT_W{1'b0}};
            inflight_r   <= 1'b0;
            addr0_hold_r <= {ADDR_WIDTH{1'b0}};
            din0_hold_r  <= {DATA_WIDTH{1'b0}};
            addr1_hold_r <= {ADDR_WIDTH{1'b0}};
            level_r      <= {LVL_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r     <= wr_ptr_nxt_s;
                addr0_hold_r <= wr_ptr_r;
                din0_hold_r  <= s.in_data;
            end else begin
                wr_ptr_r     <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r     <= rd_ptr_nxt_s;
                addr1_hold_r <= rd_ptr_r;
            end else begin
                rd_ptr_r     <= rd_ptr_r;
            end
            sram_cnt_r <= sram_cnt_nxt_s;
            inflight_r <= issue_s;
            level_r    <= level_nxt_s;
        end
    end

    // Output register stage; the head only moves on a pop so it is stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_cnt_r  <= 2'd0;
            obuf_head_r <= {DATA_WIDTH{1'b0}};
            obuf_tail_r <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            obuf_cnt_r  <= obuf_cnt_nxt_s;
            out_valid_r <= (obuf_cnt_nxt_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (obuf_cnt_r == 2'd0) begin
                        obuf_head_r <= sram_dout1;
                    end else begin
                        obuf_tail_r <= sram_dout1;
                    end
                end
                2'b01: begin
                    if (obuf_cnt_r == 2'd2) begin
                        obuf_head_r <= obuf_tail_r;
                    end else begin
                        obuf_head_r <= obuf_head_r;
                    end
                end
                2'b11: begin
                    // A returning word replaces a lone head directly, or queues behind the tail.
                    if (obuf_cnt_r == 2'd1) begin
                        obuf_head_r <= sram_dout1;
                    end else begin
                        obuf_head_r <= obuf_tail_r;
                        obuf_tail_r <= sram_dout1;
                    end
                end
                default: begin
                    obuf_head_r <= obuf_head_r;
                    obuf_tail_r <= obuf_tail_r;
                end
            endcase
        end
    end

    assign s.in_ready  = in_ready_s;
    assign s.out_valid = out_valid_r;
    assign s.out_data  = obuf_head_r;
    assign level       = level_r;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 16x8 1r1w macro and a queue scoreboard.
module tb_sram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic [AW:0]   level;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1 = 8'h00;
    logic [DW-1:0] mem [DEPTH];

    // Macro model: write at the edge, read data valid from the edge after the select.
    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus.slave),
        .level      (level),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    int            n_pop = 0;
    int            cyc = 0;
    int            first_pop_cyc = 0;
    int            last_pop_cyc = 0;
    bit            last_acc;
    bit            last_pop;
    int            acc_cnt;
    int            drained;
    int            sent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes just before the edge, update the scoreboard, then advance one cycle.
    task automatic tick();
        #1;
        last_acc = bus.in_valid && bus.in_ready;
        last_pop = bus.out_valid && bus.out_ready;
        if (!sram_csb0 && !sram_csb1)
            chk("addr_hazard", 32'(sram_addr0 == sram_addr1), 32'd0);
        if (last_acc) exp_q.push_back(bus.in_data);
        if (last_pop) begin
            chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_data_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
            if (n_pop == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            n_pop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_csb1", 32'(sram_csb1), 32'd1);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_addr1", 32'(sram_addr1), 32'd0);
        chk("rst_din0", 32'(sram_din0), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Single word through an empty FIFO
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        #1;
        chk("w1_csb0", 32'(sram_csb0), 32'd0);
        chk("w1_addr0", 32'(sram_addr0), 32'd0);
        chk("w1_din0", 32'(sram_din0), 32'hA5);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("w1_csb1", 32'(sram_csb1), 32'd0);
        chk("w1_addr1", 32'(sram_addr1), 32'd0);
        chk("w1_level_n1", 32'(level), 32'd1);
        chk("w1_valid_n1", 32'(bus.out_valid), 32'd0);
        tick();
        chk("w1_valid_n2", 32'(bus.out_valid), 32'd0);
        chk("w1_level_n2", 32'(level), 32'd1);
        tick();
        chk("w1_valid_n3", 32'(bus.out_valid), 32'd1);
        chk("w1_data_n3", 32'(bus.out_data), 32'hA5);
        chk("w1_level_n3", 32'(level), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("w1_level_after_pop", 32'(level), 32'd0);
        chk("w1_valid_after_pop", 32'(bus.out_valid), 32'd0);

        // Fill with backpressure: 18 of 20 words fit
        acc_cnt = 0;
        for (int v = 0; v < 20; v++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(v);
            tick();
            if (last_acc) acc_cnt++;
            if (bus.out_valid) chk("fill_head", 32'(bus.out_data), 32'd0);
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("fill_accepted", 32'(acc_cnt), 32'd18);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd18);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
        chk("fill_head_final", 32'(bus.out_data), 32'd0);

        // Drain at one word per cycle
        bus.out_ready = 1'b1;
        drained = 0;
        for (int k = 0; k < 30 && bus.out_valid; k++) begin
            tick();
            drained++;
            chk("drain_level", 32'(level), 32'(18 - drained));
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(drained), 32'd18);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_level_end", 32'(level), 32'd0);
        chk("drain_q_empty", 32'(exp_q.size()), 32'd0);

        // Streaming 40 words across SRAM wrap-around
        bus.out_ready = 1'b1;
        n_pop = 0;
        sent  = 0;
        for (int k = 0; k < 200 && n_pop < 40; k++) begin
            if (sent < 40) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'(sent * 3);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (last_acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_sent", 32'(sent), 32'd40);
        chk("stream_received", 32'(n_pop), 32'd40);
        chk("stream_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'd39);
        chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h50 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("mrst_level_pre", 32'(level), 32'd8);
        bus.out_ready = 1'b1;
        #1;
        chk("mrst_issue", 32'(sram_csb1), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        chk("mrst_level7", 32'(level), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_csb0", 32'(sram_csb0), 32'd1);
        chk("mrst_csb1", 32'(sram_csb1), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mrst_stale_hidden", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6 && !bus.out_valid; k++) tick();
        chk("mrst_new_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_new_data", 32'(bus.out_data), 32'h3C);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("mrst_q_empty", 32'(exp_q.size()), 32'd0);
        chk("mrst_level_end", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
